axi_mem_req_arbiter: RTL and testbench
======================================

// Module: axi_mem_req_arbiter
// PURPOSE
// - Shares one cache-line AXI memory controller between N_REQ line requesters (e.g. I-cache, D-cache, DMA).
// - Sits between the requesters and the controller's cache-side port (cache_addr/.../cache_ready).
// - Round-robin arbitration; one full-line (128-bit) read or write is in flight at a time.
// - Captures read data per transaction; optional watchdog flags a hung controller.
// PARAMETERS
// - N_REQ      2     number of requesters (2..8)
// - TIMEOUT    1024  max cycles in ARB_WAIT before error; 0 disables the watchdog
// PORTS
// - clk              in   1              single clock, all flops rising edge
// - rst_n            in   1              asynchronous active-low reset
// - req_valid        in   N_REQ          requester i has a pending line op; held high until its req_done
// - req_we           in   N_REQ          1 = line write, 0 = line read; stable while req_valid
// - req_addr         in   N_REQ x 28     byte address; controller aligns it to 16 B
// - req_wdata        in   N_REQ x 128    write line; stable while req_valid
// - req_done         out  N_REQ          one-cycle pulse to the granted requester at completion
// - req_err          out  1              high with req_done when completion was a watchdog timeout
// - req_rdata        out  128            read line, valid in the req_done cycle, held until next done
// - cache_addr       out  28             to controller
// - cache_write_data out  128            to controller
// - cache_write_req  out  1              to controller, one-cycle pulse
// - cache_read_req   out  1              to controller, one-cycle pulse
// - cache_read_data  in   128            from controller; valid once cache_ready returns high
// - cache_ready      in   1              controller idle with no request pending
// BEHAVIOUR
// - Reset (async, any time, including mid-transaction): state=ARB_IDLE; rr pointer=0; grant=0.
//   All outputs 0, including req_rdata. The controller is reset by the same rst_n.
// - FSM states: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE.
// - ARB_IDLE:
//   - If cache_ready==1 and |req_valid, pick a winner: lowest index at or after ptr, wrapping N_REQ-1 -> 0.
//   - Register the winner's index, addr, we and wdata -> ARB_ISSUE.
//   - If cache_ready==0, no grant is made; stay in ARB_IDLE.
// - ARB_ISSUE: exactly one cycle.
//   - Drive cache_addr/cache_write_data from the registered values.
//   - Assert cache_read_req=~we or cache_write_req=we for this cycle only -> ARB_WAIT.
//   - The requests are never held longer; the controller re-samples requests in its IDLE state.
// - ARB_WAIT:
//   - cache_* requests are 0; cache_addr/cache_write_data stay held.
//   - When cache_ready==1: if !we, capture cache_read_data into req_rdata -> ARB_DONE.
//   - Watchdog: a counter increments each ARB_WAIT cycle.
//   - If the counter reaches TIMEOUT (TIMEOUT!=0), set err -> ARB_DONE; req_rdata is not updated.
// - ARB_DONE: exactly one cycle.
//   - req_done[grant]=1; req_err=err.
//   - ptr <= (grant+1) mod N_REQ; clear err and the counter -> ARB_IDLE.
// - Latency:
//   - req_valid sampled in ARB_IDLE at cycle t; cache_*_req at t+1.
//   - req_done at the cycle after cache_ready is seen high in ARB_WAIT.
//   - Minimum occupancy is 4 cycles plus controller time.
// - Requester protocol:
//   - req_valid may be dropped only in the cycle after req_done; the arbiter never aborts.
//   - A requester that keeps req_valid high after req_done re-competes immediately.
//   - Rotation guarantees any other valid requester is served first.
// - Fairness bound: a valid requester waits at most N_REQ-1 transactions.
// - Simultaneous events:
//   - A new req_valid arriving during ARB_ISSUE/ARB_WAIT/ARB_DONE waits for ARB_IDLE.
//   - req_valid asserted in the same cycle as req_done for another index competes normally in the next ARB_IDLE.
// - After a timeout the controller may still be busy. ARB_IDLE blocks on cache_ready, so no overlapping issue occurs.
// STRUCTURE
// - Package axi_mem_arb_pkg:
//   - arb_state_t enum;
//   - localparams LINE_W=128, ADDR_W=28;
//   - function rr_next(ptr, n).
// - Sub-module rr_priority_picker #(N): combinational.
//   - Inputs req[N], ptr; outputs gnt_idx, gnt_any.
//   - Reused by other shared-resource arbiters.
// - Top holds the FSM, registered request, timeout counter and rdata register.
// TESTING
// - Single read: req_valid[0]=1, we=0, addr=28'h0000123; controller returns 128'hA0..A3.
//   - Expect cache_addr=28'h0000123 and cache_read_req high for 1 cycle.
//   - Expect req_done[0] 1 cycle with req_rdata=128'hA0..A3.
// - Single write: req_valid[1]=1, we=1, wdata=128'hDEADBEEF_..., addr=28'h40.
//   - Expect cache_write_req 1 cycle; 4 AXI writes to 0x40/44/48/4C; req_done[1]; req_err=0.
// - Contention: req_valid=2'b11 held for 4 transactions.
//   - Expect grant order 0,1,0,1; after reset, 0 first.
// - Back-pressure: cache_ready held 0 with req_valid[1]=1.
//   - Expect no cache_*_req until cache_ready=1, then issue on the next cycle.
// - Watchdog: TIMEOUT=16; controller never returns cache_ready.
//   - Expect req_done[0] and req_err=1 at WAIT cycle 16, req_rdata unchanged.
//   - Expect no new issue while cache_ready=0.
// - Reset mid-ARB_WAIT: deassert rst_n for 1 cycle.
//   - Expect all outputs 0 immediately and state ARB_IDLE.
//   - Expect the next grant to go to requester 0.

Source files
------------

// File: rtl/axi_mem_req_arbiter_pkg.sv
// Shared types and helpers for the cache-line memory request arbiter.
package axi_mem_arb_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/axi_mem_req_arbiter_if.sv
// Requester-side and controller-side signals of the line request arbiter.
interface axi_mem_req_arbiter_if #(
    parameter int N_REQ = 2
) ();
    import axi_mem_arb_pkg::*;

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_we;
    logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0][LINE_W-1:0] req_wdata;
    logic [N_REQ-1:0]             req_done;
    logic                         req_err;
    logic [LINE_W-1:0]            req_rdata;

    logic [ADDR_W-1:0]            cache_addr;
    logic [LINE_W-1:0]            cache_write_data;
    logic                         cache_write_req;
    logic                         cache_read_req;
    logic [LINE_W-1:0]            cache_read_data;
    logic                         cache_ready;

    // master is the arbiter; slave is the requesters plus controller around it
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, cache_read_data, cache_ready,
        output req_done, req_err, req_rdata,
        output cache_addr, cache_write_data, cache_write_req, cache_read_req
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, cache_read_data, cache_ready,
        input  req_done, req_err, req_rdata,
        input  cache_addr, cache_write_data, cache_write_req, cache_read_req
    );

endinterface

// File: rtl/axi_mem_req_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_picker #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    logic [W-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = W'((32'(ptr) + 32'(i)) % 32'(N));
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/axi_mem_req_arbiter.sv
// Round-robin arbiter sharing one cache-line memory controller between N_REQ requesters,
// with one line transaction in flight and an optional watchdog on the controller.
module axi_mem_req_arbiter
    import axi_mem_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_mem_req_arbiter_if.master bus
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;

    rr_priority_picker #(.N(N_REQ)) u_picker (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Every output is a flop; the request and done/err pulses are set on the edge
    // entering the state in which they must be visible.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        done_d   = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (bus.cache_ready && pick_any) begin
                    grant_d  = pick_idx;
                    addr_d   = bus.req_addr[pick_idx];
                    wdata_d  = bus.req_wdata[pick_idx];
                    we_d     = bus.req_we[pick_idx];
                    rd_req_d = ~bus.req_we[pick_idx];
                    wr_req_d = bus.req_we[pick_idx];
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (bus.cache_ready) begin
                    if (!we_q) rdata_d = bus.cache_read_data;
                    done_d[grant_q] = 1'b1;
                    state_d         = ARB_DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    err_d           = 1'b1;
                    done_d[grant_q] = 1'b1;
                    state_d         = ARB_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_DONE: begin
                ptr_d   = PTR_W'(rr_next(32'(grant_q), N_REQ));
                cnt_d   = '0;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            done_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            err_q    <= err_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.req_done         = done_q;
    assign bus.req_err          = err_q;
    assign bus.req_rdata        = rdata_q;
    assign bus.cache_addr       = addr_q;
    assign bus.cache_write_data = wdata_q;
    assign bus.cache_write_req  = wr_req_q;
    assign bus.cache_read_req   = rd_req_q;

endmodule

// File: tb/tb_axi_mem_req_arbiter.sv
// Directed bench for axi_mem_req_arbiter with a small behavioural line controller.
module tb_axi_mem_req_arbiter;
    import axi_mem_arb_pkg::*;

    localparam int N  = 2;
    localparam int TO = 16;
    localparam logic [127:0] LINE_A = 128'h000000A0_000000A1_000000A2_000000A3;
    localparam logic [127:0] WLINE  = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_mem_req_arbiter_if #(.N_REQ(N)) bus ();

    axi_mem_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Controller model: goes busy on a request, returns ready 4 edges later unless hung.
    logic         ctrl_idle;
    int           ctrl_lat;
    logic         hang = 1'b0;
    logic         block = 1'b0;
    logic [127:0] rd_line = LINE_A;
    logic [27:0]  seen_addr = '0;
    logic [127:0] seen_wdata = '0;
    int           n_wr = 0;
    int           n_overlap = 0;

    assign bus.cache_ready = ctrl_idle & ~block;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_idle           <= 1'b1;
            ctrl_lat            <= 0;
            bus.cache_read_data <= '0;
        end else if (bus.cache_read_req || bus.cache_write_req) begin
            if (!ctrl_idle) n_overlap <= n_overlap + 1;
            ctrl_idle  <= 1'b0;
            ctrl_lat   <= 3;
            seen_addr  <= bus.cache_addr;
            seen_wdata <= bus.cache_write_data;
            if (bus.cache_write_req) n_wr <= n_wr + 1;
        end else if (!ctrl_idle && !hang) begin
            if (ctrl_lat == 0) begin
                ctrl_idle           <= 1'b1;
                bus.cache_read_data <= rd_line;
            end else begin
                ctrl_lat <= ctrl_lat - 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_issue(input int max, output int cyc);
        cyc = 0;
        while (!(bus.cache_read_req || bus.cache_write_req) && cyc < max) begin
            step();
            cyc++;
        end
    endtask

    task automatic wait_done(input int max, output int cyc, output int extra);
        cyc   = 0;
        extra = 0;
        do begin
            step();
            cyc++;
            if (bus.cache_read_req || bus.cache_write_req) extra++;
        end while (bus.req_done == '0 && cyc < max);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int cyc, extra, quiet;
        logic [27:0] exp_addr [4];
        logic [1:0]  exp_done [4];

        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        @(negedge clk);
        step();

        // reset state
        check("rst_done",   128'(bus.req_done), 128'(2'b00));
        check("rst_err",    128'(bus.req_err), 128'(1'b0));
        check("rst_rdata",  bus.req_rdata, 128'h0);
        check("rst_rd_req", 128'(bus.cache_read_req), 128'(1'b0));
        check("rst_wr_req", 128'(bus.cache_write_req), 128'(1'b0));
        check("rst_addr",   128'(bus.cache_addr), 128'(28'h0));
        rst_n = 1'b1;
        step();

        // single read by requester 0
        bus.req_addr[0] = 28'h0000123;
        bus.req_we[0]   = 1'b0;
        bus.req_valid   = 2'b01;
        wait_issue(8, cyc);
        check("rd_issue_lat", 128'(cyc), 128'(1));
        check("rd_read_req",  128'(bus.cache_read_req), 128'(1'b1));
        check("rd_write_req", 128'(bus.cache_write_req), 128'(1'b0));
        check("rd_addr",      128'(bus.cache_addr), 128'(28'h0000123));
        wait_done(40, cyc, extra);
        check("rd_done_lat",  128'(cyc), 128'(6));
        check("rd_req_extra", 128'(extra), 128'(0));
        check("rd_done",      128'(bus.req_done), 128'(2'b01));
        check("rd_err",       128'(bus.req_err), 128'(1'b0));
        check("rd_rdata",     bus.req_rdata, LINE_A);
        bus.req_valid = '0;
        step();
        check("rd_done_pulse", 128'(bus.req_done), 128'(2'b00));
        check("rd_rdata_hold", bus.req_rdata, LINE_A);

        // single write by requester 1
        bus.req_addr[1]  = 28'h0000040;
        bus.req_we[1]    = 1'b1;
        bus.req_wdata[1] = WLINE;
        bus.req_valid    = 2'b10;
        wait_issue(8, cyc);
        check("wr_issue_lat", 128'(cyc), 128'(1));
        check("wr_write_req", 128'(bus.cache_write_req), 128'(1'b1));
        check("wr_read_req",  128'(bus.cache_read_req), 128'(1'b0));
        check("wr_wdata",     bus.cache_write_data, WLINE);
        wait_done(40, cyc, extra);
        check("wr_done_lat",  128'(cyc), 128'(6));
        check("wr_req_extra", 128'(extra), 128'(0));
        check("wr_done",      128'(bus.req_done), 128'(2'b10));
        check("wr_err",       128'(bus.req_err), 128'(1'b0));
        check("wr_rdata_kept", bus.req_rdata, LINE_A);
        check("wr_ctrl_addr", 128'(seen_addr), 128'(28'h0000040));
        check("wr_ctrl_data", seen_wdata, WLINE);
        check("wr_ctrl_count", 128'(n_wr), 128'(1));
        bus.req_valid = '0;
        bus.req_we    = '0;
        step();

        // contention: both held for four transactions, rotation 0,1,0,1
        bus.req_addr[0] = 28'h0000100;
        bus.req_addr[1] = 28'h0000200;
        exp_addr = '{28'h0000100, 28'h0000200, 28'h0000100, 28'h0000200};
        exp_done = '{2'b01, 2'b10, 2'b01, 2'b10};
        bus.req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_issue(8, cyc);
            check("cont_issue_lat", 128'(cyc), 128'((t == 0) ? 1 : 2));
            check("cont_grant_addr", 128'(bus.cache_addr), 128'(exp_addr[t]));
            wait_done(40, cyc, extra);
            check("cont_done", 128'(bus.req_done), 128'(exp_done[t]));
        end
        bus.req_valid = '0;
        step();

        // back-pressure: controller not ready holds off any issue
        block = 1'b1;
        bus.req_addr[1] = 28'h0000300;
        bus.req_valid   = 2'b10;
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.cache_read_req || bus.cache_write_req) quiet++;
        end
        check("bp_no_issue", 128'(quiet), 128'(0));
        block = 1'b0;
        wait_issue(8, cyc);
        check("bp_issue_lat", 128'(cyc), 128'(1));
        check("bp_addr", 128'(bus.cache_addr), 128'(28'h0000300));
        wait_done(40, cyc, extra);
        check("bp_done", 128'(bus.req_done), 128'(2'b10));
        bus.req_valid = '0;
        step();

        // move the pointer to 1, then reset in the middle of a hung wait
        bus.req_addr[0] = 28'h0000010;
        bus.req_valid   = 2'b01;
        wait_issue(8, cyc);
        wait_done(40, cyc, extra);
        check("pre_done", 128'(bus.req_done), 128'(2'b01));
        bus.req_valid = '0;
        step();
        hang = 1'b1;
        bus.req_addr[0] = 28'h0000020;
        bus.req_addr[1] = 28'h0000030;
        bus.req_valid   = 2'b01;
        wait_issue(8, cyc);
        step(); step(); step();
        check("mid_wait_no_done", 128'(bus.req_done), 128'(2'b00));
        rst_n = 1'b0;
        #1;
        check("mr_addr",  128'(bus.cache_addr), 128'(28'h0));
        check("mr_rdata", bus.req_rdata, 128'h0);
        check("mr_done",  128'(bus.req_done), 128'(2'b00));
        check("mr_err",   128'(bus.req_err), 128'(1'b0));
        hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        wait_issue(8, cyc);
        check("mr_issue_lat", 128'(cyc), 128'(1));
        check("mr_next_grant", 128'(bus.cache_addr), 128'(28'h0000020));
        wait_done(40, cyc, extra);
        check("mr_done_idx", 128'(bus.req_done), 128'(2'b01));
        bus.req_valid = '0;
        step();

        // watchdog: hung controller, done+err after 16 wait cycles
        hang = 1'b1;
        bus.req_addr[0] = 28'h0000050;
        bus.req_valid   = 2'b01;
        wait_issue(8, cyc);
        check("wd_issue_lat", 128'(cyc), 128'(1));
        wait_done(40, cyc, extra);
        check("wd_done_lat", 128'(cyc), 128'(TO + 1));
        check("wd_done", 128'(bus.req_done), 128'(2'b01));
        check("wd_err",  128'(bus.req_err), 128'(1'b1));
        check("wd_rdata_kept", bus.req_rdata, LINE_A);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.cache_read_req || bus.cache_write_req) quiet++;
        end
        check("wd_err_cleared", 128'(bus.req_err), 128'(1'b0));
        check("wd_no_reissue", 128'(quiet), 128'(0));
        check("no_overlap", 128'(n_overlap), 128'(0));
        bus.req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
